// File: rtl/perf_counter_reader.sv
// perf_counter_reader: owns EVENT_NUM event counters, serves single-counter
// reads (with optional clear) over a valid/ready port, and streams an atomic
// snapshot of all counters on request.
// Build option: define PERF_SAT_EN to make counters saturate instead of wrap.
module perf_counter_reader #(
  parameter int EVENT_NUM = 16,
  parameter int CNT_WIDTH = 32,
  parameter int ID_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EVENT_NUM-1:0] event_i,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ID_WIDTH-1:0]  req_id,
  input  logic                 req_clear,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [CNT_WIDTH-1:0] resp_data,
  input  logic                 dump_start,
  output logic                 dump_busy,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [ID_WIDTH-1:0]  dump_id,
  output logic [CNT_WIDTH-1:0] dump_data,
  output logic                 dump_last
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RESP = 2'd1;
  localparam logic [1:0] S_SNAP = 2'd2;
  localparam logic [1:0] S_DUMP = 2'd3;
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(EVENT_NUM - 1);

  logic [1:0]                          r_state;
  logic                                r_dump_pend;
  logic [CNT_WIDTH-1:0]                r_resp_data;
  logic [ID_WIDTH-1:0]                 r_dump_id;
  logic [EVENT_NUM-1:0][CNT_WIDTH-1:0] w_cnt;
  logic [EVENT_NUM-1:0][CNT_WIDTH-1:0] w_snap;
  logic                                w_idle;
  logic                                w_take_dump;
  logic                                w_req_acc;

  // A dump (fresh or deferred from RESP) wins over a read in IDLE; req_ready
  // drops in that case so the handshake never reports a phantom accept.
  assign w_idle      = (r_state == S_IDLE);
  assign w_take_dump = w_idle & (dump_start | r_dump_pend);
  assign req_ready   = rst & w_idle & ~w_take_dump;
  assign w_req_acc   = req_ready & req_valid;

  genvar gi;
  generate
    for (gi = 0; gi < EVENT_NUM; gi++) begin : g_lane
      logic                 w_clr;
      logic [CNT_WIDTH-1:0] w_base;
      logic [CNT_WIDTH-1:0] w_next;
      logic [CNT_WIDTH-1:0] r_cnt;
      logic [CNT_WIDTH-1:0] r_snap;

      // Clear happens before this cycle's event, so a coincident pulse counts.
      assign w_clr  = w_req_acc & req_clear & (req_id == ID_WIDTH'(gi));
      assign w_base = w_clr ? '0 : r_cnt;
`ifdef PERF_SAT_EN
      assign w_next = (&w_base) ? w_base : w_base + CNT_WIDTH'(event_i[gi]);
`else
      assign w_next = w_base + CNT_WIDTH'(event_i[gi]);
`endif
      assign w_cnt[gi]  = r_cnt;
      assign w_snap[gi] = r_snap;

      // Counter runs in every FSM state.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else      r_cnt <= w_next;
      end

      // Snapshot captures pre-increment values for all lanes in one cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_snap <= '0;
        else if (r_state == S_SNAP) r_snap <= r_cnt;
      end
    end
  endgenerate

  // Control FSM: read response, snapshot and dump sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_dump_pend <= 1'b0;
      r_resp_data <= '0;
      r_dump_id   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take_dump) begin
            r_state     <= S_SNAP;
            r_dump_pend <= 1'b0;
          end else if (w_req_acc) begin
            r_resp_data <= w_cnt[req_id];
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (dump_start) r_dump_pend <= 1'b1;
          if (resp_ready) r_state <= S_IDLE;
        end
        S_SNAP: begin
          r_state   <= S_DUMP;
          r_dump_id <= '0;
        end
        S_DUMP: begin
          if (dump_ready) begin
            if (r_dump_id == LAST_ID) begin
              r_state   <= S_IDLE;
              r_dump_id <= '0;
            end else begin
              r_dump_id <= r_dump_id + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_resp_data;
  assign dump_busy  = (r_state == S_SNAP) | (r_state == S_DUMP);
  assign dump_valid = (r_state == S_DUMP);
  assign dump_id    = r_dump_id;
  assign dump_data  = dump_valid ? w_snap[r_dump_id] : '0;
  assign dump_last  = dump_valid & (r_dump_id == LAST_ID);

endmodule

// File: tb/tb_perf_counter_reader.sv
// Directed bench for perf_counter_reader: reads, read-clear, dump with
// stalls, dump/read priority, narrow-counter wrap/saturate, mid-dump reset.
module tb_perf_counter_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] event_i = '0;
  logic        req_valid = 0, req_clear = 0, resp_ready = 0;
  logic        dump_start = 0, dump_ready = 0;
  logic [3:0]  req_id = '0;
  logic        req_ready, resp_valid, dump_busy, dump_valid, dump_last;
  logic [31:0] resp_data, dump_data;
  logic [3:0]  dump_id;

  // narrow instance for wrap/saturation
  logic [1:0]  u1_event = '0;
  logic        u1_req_valid = 0, u1_resp_ready = 0;
  logic [0:0]  u1_req_id = '0;
  logic        u1_req_ready, u1_resp_valid, u1_dump_busy, u1_dump_valid, u1_dump_last;
  logic [3:0]  u1_resp_data, u1_dump_data;
  logic [0:0]  u1_dump_id;

  int n_chk = 0;
  int n_fail = 0;
  int n_ev, beat, t;

  always #5 clk = ~clk;

  perf_counter_reader #(.EVENT_NUM(16), .CNT_WIDTH(32), .ID_WIDTH(4)) u0 (
    .clk(clk), .rst(rst), .event_i(event_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id), .req_clear(req_clear),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_id(dump_id), .dump_data(dump_data), .dump_last(dump_last));

  perf_counter_reader #(.EVENT_NUM(2), .CNT_WIDTH(4), .ID_WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .event_i(u1_event),
    .req_valid(u1_req_valid), .req_ready(u1_req_ready), .req_id(u1_req_id), .req_clear(1'b0),
    .resp_valid(u1_resp_valid), .resp_ready(u1_resp_ready), .resp_data(u1_resp_data),
    .dump_start(1'b0), .dump_busy(u1_dump_busy), .dump_valid(u1_dump_valid),
    .dump_ready(1'b0), .dump_id(u1_dump_id), .dump_data(u1_dump_data), .dump_last(u1_dump_last));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // single read of u0; ev is applied only in the accept cycle
  task automatic rd(input int id, input logic clr, input logic [15:0] ev,
                    input logic [31:0] exp, input string tag);
    chk({tag, "_rdy"}, 32'(req_ready), 1);
    req_valid = 1; req_id = 4'(id); req_clear = clr; event_i = ev;
    tick();
    req_valid = 0; req_clear = 0; event_i = '0;
    chk({tag, "_vld"}, 32'(resp_valid), 1);
    chk(tag, resp_data, exp);
    resp_ready = 1;
    tick();
    resp_ready = 0;
    chk({tag, "_done"}, 32'(resp_valid), 0);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_dump_busy", 32'(dump_busy), 0);
    chk("rst_dump_valid", 32'(dump_valid), 0);
    chk("rst_dump_id", 32'(dump_id), 0);
    chk("rst_dump_data", dump_data, 0);
    chk("rst_dump_last", 32'(dump_last), 0);
    tick(); tick();
    rst = 1;
    tick();

    // 5 pulses on event 3, two non-clearing reads
    event_i = 16'h0008;
    repeat (5) tick();
    event_i = '0;
    rd(3, 0, '0, 5, "rd3_a");
    rd(3, 0, '0, 5, "rd3_b");

    // counter 2 = 7; clearing read with coincident event
    event_i = 16'h0004;
    repeat (7) tick();
    event_i = '0;
    rd(2, 1, 16'h0004, 7, "rd2_clr");
    rd(2, 0, '0, 1, "rd2_after");

    // clear every counter, then preload counter i to 2*i
    for (int i = 0; i < 16; i++)
      rd(i, 1, '0, (i == 3) ? 5 : (i == 2) ? 1 : 0, $sformatf("clr%0d", i));
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 16; i++) event_i[i] = (k < 2 * i);
      tick();
    end
    event_i = '0;

    // dump with toggling ready, events running, a stray dump_start mid-dump
    dump_start = 1;
    tick();
    dump_start = 0;
    chk("snap_busy", 32'(dump_busy), 1);
    chk("snap_valid", 32'(dump_valid), 0);
    event_i = 16'hFFFF; n_ev = 0;
    tick(); n_ev++;
    beat = 0;
    for (int k = 0; k < 100 && beat < 16; k++) begin
      chk($sformatf("dmp_vld_k%0d", k), 32'(dump_valid), 1);
      chk($sformatf("dmp_id_k%0d", k), 32'(dump_id), 32'(beat));
      chk($sformatf("dmp_data_k%0d", k), dump_data, 32'(beat * 2));
      chk($sformatf("dmp_last_k%0d", k), 32'(dump_last), 32'(beat == 15));
      chk($sformatf("dmp_rdy_k%0d", k), 32'(req_ready), 0);
      dump_ready = (k % 2 == 0);
      dump_start = (k == 3);
      tick(); n_ev++;
      if (k % 2 == 0) beat++;
    end
    dump_ready = 0; dump_start = 0; event_i = '0;
    chk("dmp_beats", 32'(beat), 16);
    chk("dmp_end_busy", 32'(dump_busy), 0);
    chk("dmp_end_valid", 32'(dump_valid), 0);
    tick();
    chk("dmp_stray_ignored", 32'(dump_busy), 0);
    rd(9, 0, '0, 32'(18 + n_ev), "rd9_post_dump");

    // dump_start and req_valid together: dump wins, read completes after
    req_valid = 1; req_id = 4'd5; dump_start = 1;
    #1;
    chk("prio_rdy", 32'(req_ready), 0);
    tick();
    dump_start = 0;
    chk("prio_snap", 32'(dump_busy), 1);
    event_i = 16'h0020; t = 0;
    dump_ready = 1;
    for (int k = 0; k < 40 && dump_busy; k++) begin
      chk($sformatf("prio_rdy_k%0d", k), 32'(req_ready), 0);
      chk($sformatf("prio_resp_k%0d", k), 32'(resp_valid), 0);
      tick(); t++;
      if (t == 5) event_i = '0;
    end
    dump_ready = 0;
    chk("prio_dump_done", 32'(dump_busy), 0);
    chk("prio_rdy_idle", 32'(req_ready), 1);
    tick();
    req_valid = 0;
    chk("prio_resp_vld", 32'(resp_valid), 1);
    chk("prio_resp_data", resp_data, 32'(10 + n_ev + 5));
    resp_ready = 1; tick(); resp_ready = 0;

    // narrow counter: 17 pulses
    u1_event = 2'b01;
    repeat (17) tick();
    u1_event = '0;
    u1_req_valid = 1; u1_req_id = '0;
    tick();
    u1_req_valid = 0;
    chk("nar_vld", 32'(u1_resp_valid), 1);
`ifdef PERF_SAT_EN
    chk("nar_data", 32'(u1_resp_data), 15);
`else
    chk("nar_data", 32'(u1_resp_data), 1);
`endif
    u1_resp_ready = 1; tick(); u1_resp_ready = 0;

    // reset in the middle of a dump at beat 6
    event_i = 16'h0080;
    dump_start = 1; tick(); dump_start = 0;
    tick();
    dump_ready = 1;
    for (int k = 0; k < 20 && !(dump_valid && dump_id == 4'd6); k++) tick();
    dump_ready = 0;
    chk("mid_at_beat6", 32'(dump_id), 6);
    rst = 0;
    #1;
    chk("mid_dump_valid", 32'(dump_valid), 0);
    chk("mid_dump_busy", 32'(dump_busy), 0);
    chk("mid_resp_valid", 32'(resp_valid), 0);
    chk("mid_dump_id", 32'(dump_id), 0);
    chk("mid_dump_data", dump_data, 0);
    chk("mid_req_ready", 32'(req_ready), 0);
    event_i = '0;
    tick();
    rst = 1;
    tick();
    chk("post_rst_rdy", 32'(req_ready), 1);
    rd(7, 0, '0, 0, "post_rst_rd7");
    rd(9, 0, '0, 0, "post_rst_rd9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/perf_counter_reader.md
Name: perf_counter_reader

Overview:
- Read-side counterpart of the PERF event counters: owns EVENT_NUM hardware event counters and serves them to a debug/CSR initiator.
- Counters are fed by single-cycle event pulses.
- Serves single-counter reads (optional clear) over a valid/ready request/response port.
- A dump engine snapshots all counters atomically and streams them out for the difftest log path.

Parameters:
- EVENT_NUM, 16, number of event inputs/counters (power of two, >=2)
- CNT_WIDTH, 32, counter width in bits
- ID_WIDTH, 4, counter index width; must equal $clog2(EVENT_NUM)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low (asserted when rst == `RST, i.e. 0; sampled on negedge rst)
- event_i  in  EVENT_NUM  per-event increment pulse; one count per cycle high
- req_valid  in  1  read request valid
- req_ready  out  1  request accepted when valid&ready
- req_id  in  ID_WIDTH  counter index to read
- req_clear  in  1  clear counter after read
- resp_valid  out  1  read response valid
- resp_ready  in  1  response consumed when valid&ready
- resp_data  out  CNT_WIDTH  counter value
- dump_start  in  1  one-cycle pulse: snapshot and stream all counters
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  dump beat consumed when valid&ready
- dump_id  out  ID_WIDTH  index of current dump beat
- dump_data  out  CNT_WIDTH  snapshot value of current beat
- dump_last  out  1  high on beat EVENT_NUM-1

Behaviour:
- Reset values: all counters and snapshot registers 0; FSM in IDLE. Outputs: req_ready=0, resp_valid=0, resp_data=0, dump_busy=0, dump_valid=0, dump_id=0, dump_data=0, dump_last=0.
- Counting: every cycle, counter[i] <= counter[i] + event_i[i]. Counts continue in all FSM states, including during a dump. Wraps modulo 2^CNT_WIDTH (see optional feature).
- FSM states: IDLE, RESP, SNAP, DUMP.
- IDLE:
  - req_ready=1.
  - dump_start has priority over req_valid in the same cycle: go to SNAP, request not accepted.
  - Otherwise req_valid -> latch counter[req_id] into resp_data (value before this cycle's event increment), go to RESP.
  - resp_valid rises the cycle after acceptance (1-cycle latency).
- Read clear: if req_clear is accepted, counter[req_id] <= event_i[req_id] in the acceptance cycle. A simultaneous event is counted after the clear, so the counter holds 1, not 0.
- RESP:
  - req_ready=0; resp_valid=1; resp_data stable until resp_ready.
  - On handshake -> IDLE. No back-to-back accept in the handshake cycle: one request per two cycles maximum.
  - dump_start in RESP is latched as pending and taken on return to IDLE.
- SNAP: one cycle. snapshot[i] <= counter[i] for all i, simultaneously, pre-increment values. dump_busy=1. Then -> DUMP with dump_id=0.
- DUMP:
  - dump_valid=1; dump_data=snapshot[dump_id]; dump_last=(dump_id==EVENT_NUM-1).
  - On handshake, dump_id increments; after the last beat -> IDLE with dump_id=0.
  - req_ready=0 throughout.
  - dump_start during SNAP/DUMP is ignored, not queued.
- dump_busy=1 in SNAP and DUMP only.
- Stalls: beat outputs hold stable while valid&!ready.
- Reset mid-operation: asynchronous return to reset state. Any in-flight response or dump is dropped with no partial-beat completion.
- req_id is always in range: EVENT_NUM is a power of two and ID_WIDTH is exact.

Optional Feature:
- Macro: PERF_SAT_EN.
- Defined: each counter saturates at 2^CNT_WIDTH-1 and holds until cleared.
- Undefined: counters wrap to 0 silently, matching DIFFTEST PERF counters.
- Clear and snapshot semantics are identical in both builds.

Test Plan:
- Pulse event_i[3] for 5 cycles, then read id 3 with req_clear=0 -> resp_data=5 one cycle after accept; a second read -> 5.
- Counter 2 = 7; read id 2 with req_clear=1 while event_i[2]=1 in the accept cycle -> resp_data=7; next read -> 1.
- Counters 0..15 preloaded to i*2; dump_start with dump_ready toggling 1/0 -> 16 beats, dump_id 0..15, data i*2. Events during the dump do not change the beats; dump_last only on beat 15.
- dump_start and req_valid in the same IDLE cycle -> dump wins, req_ready=0 until the dump finishes, then the request completes with a post-dump value.
- CNT_WIDTH=4, 17 pulses on event 0 -> reads 1 without PERF_SAT_EN, 15 with it.
- Assert rst=0 mid-dump at beat 6 -> dump_valid, dump_busy, resp_valid and all counters are 0 immediately; after release, req_ready=1.
